// File: rtl/tile_game_pkg.sv
// Shared types and constants for the six-tile pair-matching game.
//   - state_e     : game FSM states
//   - SEG_*       : active-low seven-segment patterns (bit 6 = segment g)
//   - sym_to_seg  : symbol digit -> seven-segment pattern
package tile_game_pkg;

    localparam int N_TILES = 6;
    localparam int SYM_W   = 3;
    localparam int IDX_W   = $clog2(N_TILES);
    localparam int N_PAIRS = N_TILES / 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK1 = 3'd1,
        ST_PICK2 = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WIN   = 3'd4
    } state_e;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;

    // Full 0..7 decode so a different LAYOUT still displays sensibly.
    function automatic logic [6:0] sym_to_seg(input logic [SYM_W-1:0] sym);
        logic [6:0] seg;
        case (sym)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tile_game_tick.sv
// Tick divider: counts 0..TICK_DIV-1 and raises tick_en for one cycle on
// the last count. clr restarts the count from zero so a timed interval
// can begin on a known phase.
//   clk     in  clock
//   srst    in  synchronous active-high reset
//   clr     in  synchronous counter clear
//   tick_en out one-cycle pulse every TICK_DIV cycles
module tile_game_tick #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    output logic tick_en
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_en = (cnt_q == LAST);

endmodule

// File: rtl/tile_game.sv
// Six-tile memory (pair-matching) game, DE1-SoC top level.
//   CLOCK_50  in   sole clock
//   KEY[0]    in   synchronous active-high reset
//   KEY[1]    in   start / new game (active-low button, falling edge)
//   KEY[3:2]  in   unused
//   SW[5:0]   in   tile flip requests (rising edge flips tile i)
//   SW[9:6]   in   unused
//   LEDR      out  [3:0] moves, [6:4] pairs matched, [8:7] 0, [9] win
//   HEX0..5   out  active-low seven-segment, HEXi shows tile i
// All outputs are registered from the current state, so the display
// follows a state change by one cycle.
module tile_game
    import tile_game_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int HOLD_TICKS = 2,
    // Tile 0 in the LSBs: t0=1 t1=2 t2=3 t3=1 t4=3 t5=2.
    parameter logic [N_TILES*SYM_W-1:0] LAYOUT = 18'o231321
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic srst;
    assign srst = KEY[0];

    logic unused_inputs;
    assign unused_inputs = ^{KEY[3:2], SW[9:6]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [N_TILES-1:0]   sw_prev_q, sw_prev_d;
    logic                 key1_prev_q, key1_prev_d;
    logic [N_TILES-1:0]   revealed_q, revealed_d;   // face-up, not yet matched
    logic [N_TILES-1:0]   matched_q, matched_d;
    logic [IDX_W-1:0]     first_q, first_d;
    logic [IDX_W-1:0]     second_q, second_d;
    logic [3:0]           moves_q, moves_d;
    logic [2:0]           pairs_q, pairs_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [9:0]           ledr_q, ledr_d;
    logic [6:0]           hex_q [N_TILES];
    logic [6:0]           hex_d [N_TILES];

    logic                 tick_en;
    logic                 tick_clr;

    function automatic logic [SYM_W-1:0] tile_sym(input logic [IDX_W-1:0] idx);
        return LAYOUT[int'(idx)*SYM_W +: SYM_W];
    endfunction

    // ------------------------------------------------------------------
    // Edge detection and flip arbitration
    // ------------------------------------------------------------------
    logic [N_TILES-1:0] sw_rise;
    logic               start;
    logic               flip_any;
    logic [IDX_W-1:0]   flip_idx;
    logic [N_TILES-1:0] flip_bit;
    logic               flip_ok;

    assign sw_rise = SW[N_TILES-1:0] & ~sw_prev_q;
    assign start   = key1_prev_q & ~KEY[1];

    // Only the lowest-index edge is considered; if that tile is not
    // flippable the whole request is dropped rather than falling through
    // to a higher index.
    always_comb begin
        flip_idx = '0;
        for (int i = N_TILES - 1; i >= 0; i--) begin
            if (sw_rise[i]) begin
                flip_idx = IDX_W'(i);
            end
        end
    end

    assign flip_any = |sw_rise;
    assign flip_bit = {{(N_TILES-1){1'b0}}, 1'b1} << flip_idx;
    assign flip_ok  = flip_any && !revealed_q[flip_idx] && !matched_q[flip_idx];

    // ------------------------------------------------------------------
    // Hold timer: restart the divider on HOLD entry so the hold lasts
    // exactly HOLD_TICKS*TICK_DIV cycles.
    // ------------------------------------------------------------------
    assign tick_clr = (state_d == ST_HOLD) && (state_q != ST_HOLD);

    tile_game_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (CLOCK_50),
        .srst    (srst),
        .clr     (tick_clr),
        .tick_en (tick_en)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            sw_prev_q   <= '0;
            key1_prev_q <= 1'b1;
            revealed_q  <= '0;
            matched_q   <= '0;
            first_q     <= '0;
            second_q    <= '0;
            moves_q     <= '0;
            pairs_q     <= '0;
            hold_cnt_q  <= '0;
            ledr_q      <= '0;
            for (int i = 0; i < N_TILES; i++) begin
                hex_q[i] <= SEG_DASH;
            end
        end else begin
            state_q     <= state_d;
            sw_prev_q   <= sw_prev_d;
            key1_prev_q <= key1_prev_d;
            revealed_q  <= revealed_d;
            matched_q   <= matched_d;
            first_q     <= first_d;
            second_q    <= second_d;
            moves_q     <= moves_d;
            pairs_q     <= pairs_d;
            hold_cnt_q  <= hold_cnt_d;
            ledr_q      <= ledr_d;
            for (int i = 0; i < N_TILES; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sw_prev_d   = SW[N_TILES-1:0];
        key1_prev_d = KEY[1];
        revealed_d  = revealed_q;
        matched_d   = matched_q;
        first_d     = first_q;
        second_d    = second_q;
        moves_d     = moves_q;
        pairs_d     = pairs_q;
        hold_cnt_d  = hold_cnt_q;

        if (start) begin
            // Start from any state begins a fresh game.
            state_d    = ST_PICK1;
            revealed_d = '0;
            matched_d  = '0;
            moves_d    = '0;
            pairs_d    = '0;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_PICK1: begin
                    if (flip_ok) begin
                        revealed_d = revealed_q | flip_bit;
                        first_d    = flip_idx;
                        state_d    = ST_PICK2;
                    end
                end
                ST_PICK2: begin
                    // Tile 'first' is revealed, so flip_ok already excludes it.
                    if (flip_ok) begin
                        if (moves_q != 4'd15) begin
                            moves_d = moves_q + 4'd1;
                        end
                        if (tile_sym(flip_idx) == tile_sym(first_q)) begin
                            matched_d  = matched_q | flip_bit | ({{(N_TILES-1){1'b0}}, 1'b1} << first_q);
                            revealed_d = '0;
                            pairs_d    = pairs_q + 3'd1;
                            state_d    = (pairs_q == 3'(N_PAIRS - 1)) ? ST_WIN : ST_PICK1;
                        end else begin
                            revealed_d = revealed_q | flip_bit;
                            second_d   = flip_idx;
                            hold_cnt_d = '0;
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_en) begin
                        if (hold_cnt_q == HW'(HOLD_TICKS - 1)) begin
                            revealed_d = '0;
                            state_d    = ST_PICK1;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and WIN only react to start.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered one cycle later)
    // ------------------------------------------------------------------
    always_comb begin
        ledr_d = {(state_q == ST_WIN), 2'b00, pairs_q, moves_q};
        for (int i = 0; i < N_TILES; i++) begin
            hex_d[i] = (revealed_q[i] || matched_q[i])
                     ? sym_to_seg(LAYOUT[i*SYM_W +: SYM_W])
                     : SEG_DASH;
        end
    end

    assign LEDR = ledr_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_tile_game.sv
// Bench for tile_game with a fast tick (TICK_DIV=3). A game-rule model
// tracks which tiles are face up and the score, and a compare process
// checks every output on every falling edge; a few literal checks pin
// the model against hand-worked values.
module tb_tile_game;

    logic       clk = 1'b0;
    logic [3:0] KEY = 4'b1111;
    logic [9:0] SW  = '0;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    tile_game #(
        .TICK_DIV   (3),
        .HOLD_TICKS (2)
    ) dut (
        .CLOCK_50 (clk),
        .KEY      (KEY),
        .SW       (SW),
        .LEDR     (LEDR),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    // ---------------- game-rule model ----------------
    localparam int P_IDLE = 0, P_PICK1 = 1, P_PICK2 = 2, P_HOLD = 3, P_WIN = 4;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam int HOLD_CYCLES = 2 * 3;

    int         sym_tab [6] = '{1, 2, 3, 1, 3, 2};
    int         m_phase;
    bit         m_up [6];      // face up but not matched
    bit         m_done [6];    // matched
    int         m_first, m_second, m_moves, m_pairs, m_hold_left;
    logic [5:0] m_sw_prev;
    logic       m_key_prev;
    bit         m_valid = 0;
    logic [9:0] exp_ledr;
    logic [6:0] exp_hex [6];

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 6; i++) begin
            m_up[i]   = 0;
            m_done[i] = 0;
        end
        m_moves = 0;
        m_pairs = 0;
    endtask

    task automatic model_step();
        logic [5:0] rise;
        bit         go;
        int         t;
        if (KEY[0]) begin
            model_clear();
            m_phase    = P_IDLE;
            m_sw_prev  = '0;
            m_key_prev = 1'b1;
            exp_ledr   = '0;
            for (int i = 0; i < 6; i++) exp_hex[i] = DASH;
            m_valid = 1;
            return;
        end
        // outputs reflect the state held before this edge
        exp_ledr = 10'((m_phase == P_WIN) ? 512 : 0) + 10'(m_pairs * 16) + 10'(m_moves);
        for (int i = 0; i < 6; i++)
            exp_hex[i] = (m_up[i] || m_done[i]) ? digit_seg(sym_tab[i]) : DASH;

        rise       = SW[5:0] & ~m_sw_prev;
        go         = m_key_prev && !KEY[1];
        m_sw_prev  = SW[5:0];
        m_key_prev = KEY[1];
        t = -1;
        for (int i = 0; i < 6; i++) if (rise[i] && t < 0) t = i;
        if (t >= 0 && (m_up[t] || m_done[t])) t = -1;

        if (go) begin
            model_clear();
            m_phase = P_PICK1;
        end else if (m_phase == P_PICK1 && t >= 0) begin
            m_up[t] = 1;
            m_first = t;
            m_phase = P_PICK2;
        end else if (m_phase == P_PICK2 && t >= 0) begin
            m_up[t] = 1;
            if (m_moves < 15) m_moves++;
            if (sym_tab[t] == sym_tab[m_first]) begin
                m_up[t] = 0; m_up[m_first] = 0;
                m_done[t] = 1; m_done[m_first] = 1;
                m_pairs++;
                m_phase = (m_pairs == 3) ? P_WIN : P_PICK1;
            end else begin
                m_second    = t;
                m_hold_left = HOLD_CYCLES;
                m_phase     = P_HOLD;
            end
        end else if (m_phase == P_HOLD) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_up[m_first]  = 0;
                m_up[m_second] = 0;
                m_phase = P_PICK1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            logic [51:0] got, want;
            got  = {LEDR, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
            want = {exp_ledr, exp_hex[5], exp_hex[4], exp_hex[3],
                    exp_hex[2], exp_hex[1], exp_hex[0]};
            check_cnt++;
            if (got === want) pass_cnt++;
            else $display("FAIL cycle_model t=%0t got=%h want=%h", $time, got, want);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        check_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s got=%h want=%h", name, act, want);
    endtask

    initial begin
        // reset
        KEY = 4'b1111; SW = '0;
        cyc(3);
        chk("reset_ledr", 16'(LEDR), 16'h0000);
        chk("reset_hex0", 16'(HEX0), 16'(DASH));
        KEY = 4'b1110;
        cyc(2);

        // start
        KEY[1] = 1'b0; cyc(1);
        KEY[1] = 1'b1; cyc(1);
        chk("start_ledr", 16'(LEDR), 16'h0000);
        chk("start_hex5", 16'(HEX5), 16'(DASH));

        // mismatch 0,2
        SW = 10'd1; cyc(2);
        SW = 10'd5; cyc(2);
        $display("txn mismatch(0,2) LEDR=%h HEX0=%b HEX2=%b", LEDR, HEX0, HEX2);
        chk("mis_hex0", 16'(HEX0), 16'b1111001);
        chk("mis_hex2", 16'(HEX2), 16'b0110000);
        chk("mis_moves", 16'(LEDR[3:0]), 16'd1);
        cyc(5);
        chk("hold_still_shown", 16'(HEX2), 16'b0110000);
        cyc(1);
        chk("hold_hidden0", 16'(HEX0), 16'(DASH));
        chk("hold_hidden2", 16'(HEX2), 16'(DASH));

        // match 0,3
        SW = 10'd0; cyc(1);
        SW = 10'd1; cyc(1);
        SW = 10'd9; cyc(2);
        $display("txn match(0,3) LEDR=%h HEX0=%b HEX3=%b", LEDR, HEX0, HEX3);
        chk("match_hex3", 16'(HEX3), 16'b1111001);
        chk("match_pairs", 16'(LEDR[6:4]), 16'd1);

        // re-flip matched tile 0: ignored
        SW = 10'd8; cyc(1);
        SW = 10'd9; cyc(2);
        $display("txn reflip(0) LEDR=%h", LEDR);
        chk("reflip_ledr", 16'(LEDR), 16'h0012);

        // pairs (1,5) and (2,4)
        SW = 10'd0; cyc(1);
        SW = 10'h002; cyc(1);
        SW = 10'h022; cyc(2);
        $display("txn match(1,5) LEDR=%h", LEDR);
        SW = 10'd0; cyc(1);
        SW = 10'h004; cyc(1);
        SW = 10'h014; cyc(2);
        $display("txn match(2,4) LEDR=%h", LEDR);
        chk("win_ledr", 16'(LEDR), 16'h0234);
        chk("win_hex5", 16'(HEX5), 16'b0100100);

        // new game from WIN
        SW = 10'd0;
        KEY[1] = 1'b0; cyc(1);
        KEY[1] = 1'b1; cyc(1);
        $display("txn new_game LEDR=%h", LEDR);
        chk("newgame_ledr", 16'(LEDR), 16'h0000);

        // reset during HOLD
        SW = 10'd1; cyc(1);
        SW = 10'd5; cyc(2);
        KEY[0] = 1'b1; cyc(1);
        $display("txn reset_in_hold LEDR=%h HEX0=%b", LEDR, HEX0);
        chk("hreset_ledr", 16'(LEDR), 16'h0000);
        chk("hreset_hex0", 16'(HEX0), 16'(DASH));
        KEY[0] = 1'b0; SW = 10'd0; cyc(1);

        // simultaneous edges: lowest index wins
        KEY[1] = 1'b0; cyc(1);
        KEY[1] = 1'b1; cyc(1);
        SW = 10'd3; cyc(2);
        $display("txn multi_edge HEX0=%b HEX1=%b", HEX0, HEX1);
        chk("multi_hex0", 16'(HEX0), 16'b1111001);
        chk("multi_hex1", 16'(HEX1), 16'(DASH));

        // moves saturate at 15 after 16 mismatches
        SW = 10'd0; cyc(1);
        SW = 10'd2; cyc(8);
        for (int k = 0; k < 15; k++) begin
            SW = 10'd0; cyc(1);
            SW = 10'd1; cyc(1);
            SW = 10'd2; cyc(8);
        end
        $display("txn saturate LEDR=%h", LEDR);
        chk("sat_moves", 16'(LEDR[3:0]), 16'd15);

        cyc(2);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
